uart_tx_frame_gen: RTL and testbench
====================================

# uart_tx_frame_gen

Parametrised UART transmit engine, successor to the per-system fixed-format transmitter in the CoreUARTapb datapath. It adds a built-in FIFO of configurable depth, a run-time frame format (5–9 data bits, five parity modes, 1 or 2 stop bits) and line-break generation. It sits between the APB register file, which pushes bytes, and the TX pin. It is paced by the shared one-pulse-per-bit baud tick.

## Interface
- DATA_MAX, 8: widest supported character; legal range 5..9.
- FIFO_DEPTH, 16: FIFO entries; power of two, minimum 2.
- clk in 1: system clock; all logic on the rising edge.
- reset_n in 1: asynchronous, active-low reset.
- baud_tick in 1: one-clk pulse marking each bit boundary.
- wr_en in 1: push wr_data into the FIFO.
- wr_data in DATA_MAX: character; bits above the active length are ignored.
- cfg_len in 4: data bits; values below 5 are treated as 5, values above DATA_MAX as DATA_MAX.
- cfg_par in 3: 0 none, 1 odd, 2 even, 3 mark (1), 4 space (0); 5–7 behave as none.
- cfg_stop2 in 1: 1 selects two stop bits.
- brk in 1: request line break.
- tx out 1: serial line, idle high.
- busy out 1: a frame or break is in progress (state other than IDLE).
- done out 1: one-clk pulse at the end of each frame's final stop bit.
- full out 1, empty out 1, level out clog2(FIFO_DEPTH)+1: FIFO status.
- overflow out 1: one-clk pulse when a push is dropped.

## Operation
- FIFO push/pop rules:
  - A push while full with no pop in the same clk is dropped and pulses overflow.
  - A push and pop in the same clk while full both succeed.
  - A push into an empty FIFO is not visible to the pop logic until the next clk.
- Pop and latch:
  - Pops happen only in IDLE, or at the end of the last stop bit.
  - cfg_len, cfg_par and cfg_stop2 are latched at pop. Changing them mid-frame does not affect the current frame.
- States: IDLE, LOAD, START, DATA, PARITY, STOP1, STOP2, BREAK, BRK_REC.
  - IDLE: tx=1.
    - If brk=1, go to BREAK on the next baud_tick.
    - Otherwise, if the FIFO is non-empty, pop into the shift register on this clk and go to LOAD. This transition is on clk, not on tick.
  - LOAD: on baud_tick, tx←0 and go to START.
  - START: on baud_tick, tx←d[0], bit counter←1, go to DATA.
  - DATA: on each baud_tick:
    - If counter < len, tx←d[counter] and the counter increments.
    - Otherwise, go to PARITY if parity is enabled, else STOP1.
  - Parity bit:
    - The parity accumulator XORs each data bit as it is driven.
    - tx in PARITY is: odd → ~xor; even → xor; mark → 1; space → 0.
  - On entry to STOP1, tx←1. STOP1 goes to STOP2 if stop2 is latched; otherwise STOP1 (or STOP2) ends on the next baud_tick.
  - End of frame, on that baud_tick, done pulses and:
    - if brk=1, go to BREAK with tx←0;
    - else if the FIFO is non-empty, pop, tx←0 and go to START (back-to-back, no idle gap);
    - else go to IDLE.
  - BREAK: tx=0 while brk=1. On the first baud_tick with brk=0, tx←1 and go to BRK_REC.
  - BRK_REC: go to IDLE on the next baud_tick. This guarantees at least one bit time of mark after a break.
- brk asserted mid-frame takes effect only after the frame's stop bits. Frames are never truncated.
- Reset, including mid-frame:
  - tx=1, busy=0, done=0, overflow=0, full=0, empty=1, level=0.
  - The FIFO is emptied and the state returns to IDLE.

## Timing
- tx is registered and changes only on a clk edge with baud_tick=1, except on the IDLE→LOAD transition, which leaves tx unchanged.
- Write-to-start latency for a push into an empty, idle engine:
  - empty falls 1 clk after wr_en;
  - the pop and the move to LOAD happen on the following clk;
  - the start bit begins at the first baud_tick at least 2 clk after wr_en.
- Frame length is 1 + len + (parity enabled ? 1 : 0) + (stop2 ? 2 : 1) bit periods.
- done is coincident with the tick that ends the last stop bit.
- level, full and empty update 1 clk after a push or pop.
- baud_tick arriving every clk must be supported (minimum bit period of 1 clk).

## Structure
- Shared package uart_gen2_pkg holds:
  - the state enum;
  - parity-mode constants PAR_NONE/ODD/EVEN/MARK/SPACE;
  - the cfg_len clamp function.
- Sub-module uart_tx_fifo: synchronous FIFO with DATA_MAX width, FIFO_DEPTH entries, level/full/empty outputs, and same-clk push+pop support when full.
- The top level holds the frame FSM, shift register, bit counter and parity accumulator.

## Test plan
- Even-parity frame, bit order check:
  - Stimulus: cfg_len=8, cfg_par=2, cfg_stop2=0; push 0x55; baud_tick every 4 clk.
  - Required tx sequence per tick: 0, 1,0,1,0,1,0,1,0, 0, 1, then idle high.
  - Checks: frame lasts 11 bit periods; done pulses once.
- Two pushes, back-to-back frames:
  - Stimulus: cfg_len=7, odd parity, cfg_stop2=1; push 0x41 then 0x42.
  - Required: the two frames run with no idle bit between them; the second start bit immediately follows the first frame's second stop bit.
  - Checks: done pulses twice; empty=1 after the second pop.
- Overflow:
  - Stimulus: FIFO_DEPTH=4; push 6 words with baud_tick held low.
  - Required: full=1 and level=4 after the 4th push; overflow pulses on the 5th and 6th pushes.
  - Checks: only the first 4 words are transmitted.
- Break mid-frame:
  - Stimulus: assert brk during the data bits of a frame.
  - Required: the frame completes; tx stays 0 until brk falls; then tx=1 for at least one tick.
  - Checks: a queued word waits until after BRK_REC.
- Config change mid-frame:
  - Stimulus: change cfg_len from 8 to 5 during frame 1; frame 2 is queued.
  - Required: frame 1 sends 8 data bits; frame 2 sends 5 data bits (a 0x1F push shows bits 0–4 only).
- Reset mid-frame:
  - Stimulus: drop reset_n for 1 clk during the DATA state with 3 words queued.
  - Required: tx=1 and empty=1 asynchronously.
  - Checks: no further frames after reset release; busy=0.

Source files
------------

// File: rtl/uart_gen2_pkg.sv
// Shared types and helpers for the UART transmit frame generator.
package uart_gen2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK,
    ST_BRK_REC
  } tx_state_e;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_ODD   = 3'd1;
  localparam logic [2:0] PAR_EVEN  = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam logic [3:0] LEN_MIN = 4'd5;

  // Character length is held within [LEN_MIN, len_max].
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] len_max);
    logic [3:0] r;
    r = len;
    if (len < LEN_MIN)      r = LEN_MIN;
    else if (len > len_max) r = len_max;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous character FIFO; a push and pop in the same clk succeed even when full.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == LVL_FULL);
  assign do_pop     = pop_i && !empty_o;
  // The slot freed by a same-clk pop makes room for the push.
  assign do_push    = push_i && (!full_o || do_pop);
  assign overflow_o = push_i && !do_push;
  assign rdata_o    = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit engine: FIFO-fed frame FSM with run-time format and line break.
module uart_tx_frame_gen
  import uart_gen2_pkg::*;
#(
  parameter int DATA_MAX   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          baud_tick,
  input  logic                          wr_en,
  input  logic [DATA_MAX-1:0]           wr_data,
  input  logic [3:0]                    cfg_len,
  input  logic [2:0]                    cfg_par,
  input  logic                          cfg_stop2,
  input  logic                          brk,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam logic [3:0] LEN_MAX = 4'(DATA_MAX);

  tx_state_e           state_q, state_d;
  logic                tx_q, tx_d;
  logic [DATA_MAX-1:0] sh_q, sh_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          len_q, len_d;
  logic [2:0]          pmode_q, pmode_d;
  logic                stop2_q, stop2_d;
  logic                pacc_q, pacc_d;
  logic                pop;
  logic                frame_end;
  logic [DATA_MAX-1:0] fifo_rdata;

  uart_tx_fifo #(
    .WIDTH (DATA_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (wr_en),
    .wdata_i    (wr_data),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .overflow_o (overflow)
  );

  assign frame_end = baud_tick &&
                     ((state_q == ST_STOP1 && !stop2_q) || state_q == ST_STOP2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      sh_q    <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_MIN;
      pmode_q <= PAR_NONE;
      stop2_q <= 1'b0;
      pacc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pmode_q <= pmode_d;
      stop2_q <= stop2_d;
      pacc_q  <= pacc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pmode_d = pmode_q;
    stop2_d = stop2_q;
    pacc_d  = pacc_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (brk) begin
          if (baud_tick) begin
            state_d = ST_BREAK;
            tx_d    = 1'b0;
          end
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: if (baud_tick) begin
        tx_d    = 1'b0;
        state_d = ST_START;
      end
      // Shift register is consumed LSB first; sh_q[0] is always the next bit.
      ST_START: if (baud_tick) begin
        tx_d    = sh_q[0];
        pacc_d  = sh_q[0];
        sh_d    = sh_q >> 1;
        cnt_d   = 4'd1;
        state_d = ST_DATA;
      end
      ST_DATA: if (baud_tick) begin
        if (cnt_q < len_q) begin
          tx_d   = sh_q[0];
          pacc_d = pacc_q ^ sh_q[0];
          sh_d   = sh_q >> 1;
          cnt_d  = cnt_q + 4'd1;
        end else if (pmode_q != PAR_NONE) begin
          state_d = ST_PARITY;
          case (pmode_q)
            PAR_ODD:  tx_d = ~pacc_q;
            PAR_EVEN: tx_d = pacc_q;
            PAR_MARK: tx_d = 1'b1;
            default:  tx_d = 1'b0;
          endcase
        end else begin
          state_d = ST_STOP1;
          tx_d    = 1'b1;
        end
      end
      ST_PARITY: if (baud_tick) begin
        tx_d    = 1'b1;
        state_d = ST_STOP1;
      end
      ST_STOP1: if (baud_tick && stop2_q) state_d = ST_STOP2;
      ST_STOP2: ;
      ST_BREAK: begin
        tx_d = 1'b0;
        if (baud_tick && !brk) begin
          tx_d    = 1'b1;
          state_d = ST_BRK_REC;
        end
      end
      ST_BRK_REC: if (baud_tick) state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Last stop bit ends: break wins, then a queued char starts with no idle gap.
    if (frame_end) begin
      if (brk) begin
        state_d = ST_BREAK;
        tx_d    = 1'b0;
      end else if (!empty) begin
        pop     = 1'b1;
        state_d = ST_START;
        tx_d    = 1'b0;
      end else begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    end

    if (pop) begin
      sh_d    = fifo_rdata;
      len_d   = clamp_len(cfg_len, LEN_MAX);
      pmode_d = (cfg_par > PAR_SPACE) ? PAR_NONE : cfg_par;
      stop2_d = cfg_stop2;
    end
  end

  always_comb begin
    tx   = tx_q;
    busy = (state_q != ST_IDLE);
    done = frame_end;
  end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: records the line value of every bit period and
// compares it against frames built from the character format rules.
module tb_uart_tx_frame_gen;

  localparam int DW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset_n, baud_tick, wr_en, cfg_stop2, brk;
  logic [DW-1:0] wr_data;
  logic [3:0]    cfg_len;
  logic [2:0]    cfg_par;
  logic          tx, busy, done, full, empty, overflow;
  logic [2:0]    level;

  always #5 clk = ~clk;

  uart_tx_frame_gen #(.DATA_MAX(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .wr_en(wr_en),
    .wr_data(wr_data), .cfg_len(cfg_len), .cfg_par(cfg_par), .cfg_stop2(cfg_stop2),
    .brk(brk), .tx(tx), .busy(busy), .done(done), .full(full), .empty(empty),
    .level(level), .overflow(overflow)
  );

  int tests = 0, fails = 0;
  int tick_div = 4;
  bit tick_en = 1'b1;
  bit exp_q[$];

  // Baud tick: one clk pulse every tick_div clks, driven just after the edge.
  initial begin
    int tcnt;
    tcnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tick_en) begin
        tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
        baud_tick = (tcnt == 0);
      end else baud_tick = 1'b0;
    end
  end

  // Line monitor: the tx value following every tick taken while busy.
  bit rec[$];
  bit prev_rec = 1'b0;
  int done_cnt = 0, stray_done = 0;
  always @(negedge clk) begin
    if (prev_rec) rec.push_back(tx);
    prev_rec <= busy && baud_tick;
    if (done && baud_tick)  done_cnt   <= done_cnt + 1;
    if (done && !baud_tick) stray_done <= stray_done + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference frame: start, LSB-first data, optional parity, stop bit(s).
  task automatic add_frame(input logic [7:0] d, input logic [3:0] len,
                           input logic [2:0] par, input bit st2);
    int l;
    bit x;
    l = (len < 5) ? 5 : (len > 8) ? 8 : int'(len);
    x = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(d[i]);
      x ^= d[i];
    end
    case (par)
      3'd1: exp_q.push_back(!x);
      3'd2: exp_q.push_back(x);
      3'd3: exp_q.push_back(1'b1);
      3'd4: exp_q.push_back(1'b0);
      default: ;
    endcase
    exp_q.push_back(1'b1);
    if (st2) exp_q.push_back(1'b1);
  endtask

  task automatic push(input logic [7:0] d, output bit ovf);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    ovf = overflow;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(busy == 1'b0 && empty == 1'b1) && c < 5000);
    if (c >= 5000) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting for idle, busy=%0b empty=%0b", nm, busy, empty);
    end
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic wait_rec(input string nm, input int base, input int n);
    int c;
    c = 0;
    while (rec.size() - base < n && c < 2000) begin
      cyc(1);
      c++;
    end
    if (c >= 2000) begin
      tests++; fails++;
      $display("FAIL %s: timeout, got %0d bit periods, want %0d", nm, rec.size() - base, n);
    end
  endtask

  task automatic check_seq(input string nm, input int base);
    int n, bad;
    n   = rec.size() - base;
    bad = -1;
    if (n == exp_q.size())
      for (int i = 0; i < n; i++)
        if (rec[base+i] != exp_q[i] && bad < 0) bad = i;
    tests++;
    if (n != exp_q.size() || bad >= 0) begin
      fails++;
      $display("FAIL %s: got %0d bit periods, want %0d, first differing period %0d",
               nm, n, exp_q.size(), bad);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    logic [2:0] par;
    bit         st2;
    int         div;
    int         nbits;
  } vec_t;

  initial begin
    vec_t vt[6];
    bit   exp_ovf[6];
    bit   ovf;
    int   base, d0, nw;
    logic [7:0] w;

    vt[0] = '{8'h55, 4'd8,  3'd2, 1'b0, 4, 11};
    vt[1] = '{8'h1F, 4'd5,  3'd1, 1'b1, 1, 9};
    vt[2] = '{8'hA3, 4'd12, 3'd0, 1'b0, 3, 10};
    vt[3] = '{8'h0F, 4'd2,  3'd3, 1'b1, 2, 9};
    vt[4] = '{8'hFF, 4'd6,  3'd4, 1'b0, 5, 9};
    vt[5] = '{8'h3C, 4'd7,  3'd6, 1'b1, 1, 10};
    exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset_n = 1'b0; wr_en = 1'b0; wr_data = '0; brk = 1'b0;
    cfg_len = 4'd8; cfg_par = 3'd0; cfg_stop2 = 1'b0;
    cyc(2);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    reset_n = 1'b1;
    cyc(3);
    chk("idle_tx", tx, 1);

    // Single frames over a spread of formats and bit periods.
    for (int i = 0; i < 6; i++) begin
      cfg_len = vt[i].len; cfg_par = vt[i].par; cfg_stop2 = vt[i].st2;
      tick_div = vt[i].div;
      exp_q.delete();
      add_frame(vt[i].data, vt[i].len, vt[i].par, vt[i].st2);
      exp_q.push_back(1'b1);
      base = rec.size(); d0 = done_cnt;
      push(vt[i].data, ovf);
      wait_idle($sformatf("vec%0d_idle", i));
      check_seq($sformatf("vec%0d_bits", i), base);
      chk($sformatf("vec%0d_periods", i), rec.size() - base, vt[i].nbits + 1);
      chk($sformatf("vec%0d_done", i), done_cnt - d0, 1);
    end

    // Back-to-back frames, 7 data bits, odd parity, two stop bits.
    cfg_len = 4'd7; cfg_par = 3'd1; cfg_stop2 = 1'b1; tick_div = 3;
    exp_q.delete();
    add_frame(8'h41, 4'd7, 3'd1, 1'b1);
    add_frame(8'h42, 4'd7, 3'd1, 1'b1);
    exp_q.push_back(1'b1);
    base = rec.size(); d0 = done_cnt;
    push(8'h41, ovf);
    push(8'h42, ovf);
    wait_rec("b2b_first", base, 12);
    chk("b2b_empty_after_pop2", empty, 1);
    wait_idle("b2b_idle");
    check_seq("b2b_bits", base);
    chk("b2b_done", done_cnt - d0, 2);

    // Overflow: the engine is parked in IDLE by brk with no ticks, so nothing pops.
    cfg_len = 4'd8; cfg_par = 3'd2; cfg_stop2 = 1'b0;
    tick_en = 1'b0;
    cyc(2);
    brk = 1'b1;
    cyc(1);
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      w = 8'(8'h11 * (k + 1));
      if (k < 4) add_frame(w, 4'd8, 3'd2, 1'b0);
      push(w, ovf);
      chk($sformatf("ovf_push%0d", k + 1), ovf, exp_ovf[k]);
      if (k == 3) begin
        chk("ovf_full", full, 1);
        chk("ovf_level", level, 4);
      end
    end
    chk("ovf_level_after", level, 4);
    exp_q.push_back(1'b1);
    base = rec.size(); d0 = done_cnt;
    brk = 1'b0; tick_div = 1; tick_en = 1'b1;
    wait_idle("ovf_idle");
    check_seq("ovf_bits", base);
    chk("ovf_done", done_cnt - d0, 4);

    // Break requested mid-frame, a second char queued during the break.
    cfg_len = 4'd8; cfg_par = 3'd0; cfg_stop2 = 1'b0; tick_div = 2;
    exp_q.delete();
    add_frame(8'hC6, 4'd8, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    add_frame(8'h39, 4'd8, 3'd0, 1'b0);
    exp_q.push_back(1'b1);
    base = rec.size(); d0 = done_cnt;
    push(8'hC6, ovf);
    wait_rec("brk_data", base, 4);
    brk = 1'b1;
    wait_rec("brk_hold", base, 13);
    chk("brk_tx_low", tx, 0);
    brk = 1'b0;
    push(8'h39, ovf);
    wait_idle("brk_idle");
    check_seq("brk_bits", base);
    chk("brk_done", done_cnt - d0, 2);

    // Length change mid-frame only affects the next popped char.
    cfg_len = 4'd8; cfg_par = 3'd0; cfg_stop2 = 1'b0; tick_div = 3;
    exp_q.delete();
    add_frame(8'hE7, 4'd8, 3'd0, 1'b0);
    add_frame(8'h1F, 4'd5, 3'd0, 1'b0);
    exp_q.push_back(1'b1);
    base = rec.size(); d0 = done_cnt;
    push(8'hE7, ovf);
    push(8'h1F, ovf);
    wait_rec("cfg_mid", base, 3);
    cfg_len = 4'd5;
    wait_idle("cfg_idle");
    check_seq("cfg_bits", base);
    chk("cfg_done", done_cnt - d0, 2);

    // Randomized groups of back-to-back frames.
    for (int g = 0; g < 20; g++) begin
      logic [7:0] words[3];
      cfg_len   = 4'($urandom_range(0, 15));
      cfg_par   = 3'($urandom_range(0, 7));
      cfg_stop2 = 1'($urandom_range(0, 1));
      tick_div  = int'($urandom_range(1, 5));
      nw        = int'($urandom_range(1, 3));
      exp_q.delete();
      for (int k = 0; k < nw; k++) begin
        words[k] = 8'($urandom_range(0, 255));
        add_frame(words[k], cfg_len, cfg_par, cfg_stop2);
      end
      exp_q.push_back(1'b1);
      base = rec.size(); d0 = done_cnt;
      for (int k = 0; k < nw; k++) push(words[k], ovf);
      wait_idle($sformatf("rnd%0d_idle", g));
      check_seq($sformatf("rnd%0d_bits", g), base);
      chk($sformatf("rnd%0d_done", g), done_cnt - d0, nw);
    end

    // Reset mid-frame with chars queued.
    cfg_len = 4'd8; cfg_par = 3'd2; cfg_stop2 = 1'b0; tick_div = 3;
    base = rec.size();
    for (int k = 0; k < 4; k++) push(8'(8'hA0 + k), ovf);
    wait_rec("rstmid_data", base, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_tx", tx, 1);
    chk("rstmid_empty", empty, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_level", level, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    cyc(2);
    base = rec.size(); d0 = done_cnt;
    cyc(60);
    chk("rstmid_no_frames", rec.size() - base, 0);
    chk("rstmid_busy_after", busy, 0);
    chk("rstmid_empty_after", empty, 1);
    chk("rstmid_tx_after", tx, 1);
    chk("rstmid_done_after", done_cnt - d0, 0);

    chk("done_only_on_tick", stray_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
